// File: rtl/button_renderer.sv
// Bevelled square button rasteriser: one framebuffer write per pixel,
// raster order, with ready/valid back-pressure and row-completion pulses.
module button_renderer #(
   parameter int          BORDER      = 2,
   parameter logic [11:0] COLOR_FACE  = 12'h888,
   parameter logic [11:0] COLOR_LIGHT = 12'hFFF,
   parameter logic [11:0] COLOR_DARK  = 12'h444
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        draw_button,
   input  logic [10:0] button_xpos,
   input  logic [10:0] button_ypos,
   input  logic [6:0]  button_size,
   input  logic [4:0]  button_num,
   input  logic        fb_ready,
   output logic        fb_we,
   output logic [10:0] fb_x,
   output logic [10:0] fb_y,
   output logic [11:0] fb_rgb,
   output logic        done_x,
   output logic        done_y,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, DRAW, DONE, HOLD} state_t;

   state_t      state;
   logic [10:0] xpos_l;
   logic [10:0] ypos_l;
   logic [6:0]  size_l;
   logic [4:0]  num_l;
   logic [6:0]  px;
   logic [6:0]  py;
   logic [4:0]  col;
   logic        hold_cnt;

   logic [6:0]  next_px;
   logic [6:0]  next_py;
   logic        last_px;
   logic        last_pix;

   // Bevel colour: light edge wins over dark edge where the two overlap.
   function automatic logic [11:0] pixel_colour(input logic [6:0] cx,
                                                input logic [6:0] cy,
                                                input logic [6:0] sz);
      int far_edge;
      far_edge = int'(sz) - BORDER;
      if (int'(cx) < BORDER || int'(cy) < BORDER)
         return COLOR_LIGHT;
      else if (int'(cx) >= far_edge || int'(cy) >= far_edge)
         return COLOR_DARK;
      else
         return COLOR_FACE;
   endfunction

   // Next raster position after the pixel currently presented.
   always_comb begin
      last_px  = (px == size_l - 7'd1);
      last_pix = last_px && (py == size_l - 7'd1);
      next_px  = last_px ? 7'd0 : px + 7'd1;
      next_py  = last_px ? py + 7'd1 : py;
   end

   // Control FSM with registered outputs; the first DRAW cycle only loads
   // the first pixel, so fb_we rises one cycle after the request is taken.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         fb_we    <= 1'b0;
         fb_x     <= '0;
         fb_y     <= '0;
         fb_rgb   <= '0;
         done_x   <= 1'b0;
         done_y   <= 1'b0;
         busy     <= 1'b0;
         col      <= '0;
         px       <= '0;
         py       <= '0;
         xpos_l   <= '0;
         ypos_l   <= '0;
         size_l   <= '0;
         num_l    <= '0;
         hold_cnt <= 1'b0;
      end else begin
         done_x <= 1'b0;
         done_y <= 1'b0;
         case (state)
            IDLE: begin
               if (draw_button && button_size != 7'd0) begin
                  xpos_l <= button_xpos;
                  ypos_l <= button_ypos;
                  size_l <= button_size;
                  num_l  <= button_num;
                  px     <= '0;
                  py     <= '0;
                  busy   <= 1'b1;
                  state  <= DRAW;
               end
            end
            DRAW: begin
               if (!fb_we) begin
                  fb_we  <= 1'b1;
                  fb_x   <= xpos_l + {4'd0, px};
                  fb_y   <= ypos_l + {4'd0, py};
                  fb_rgb <= pixel_colour(px, py, size_l);
               end else if (fb_ready) begin
                  if (last_pix) begin
                     fb_we  <= 1'b0;
                     done_x <= 1'b1;
                     state  <= DONE;
                     // A row count of 0 or 1 means every button ends a row.
                     if (num_l <= 5'd1 || col >= num_l - 5'd1) begin
                        done_y <= 1'b1;
                        col    <= '0;
                     end else begin
                        col <= col + 5'd1;
                     end
                  end else begin
                     px     <= next_px;
                     py     <= next_py;
                     fb_x   <= xpos_l + {4'd0, next_px};
                     fb_y   <= ypos_l + {4'd0, next_py};
                     fb_rgb <= pixel_colour(next_px, next_py, size_l);
                  end
               end
            end
            DONE: begin
               hold_cnt <= 1'b0;
               state    <= HOLD;
            end
            HOLD: begin
               // Two idle cycles give upstream time to update the position.
               if (hold_cnt) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  hold_cnt <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_button_renderer.sv
// Self-checking bench for button_renderer: random positions/sizes and
// random back-pressure against a raster reference model.
module tb_button_renderer;

   localparam int          BORDER = 2;
   localparam logic [11:0] C_FACE  = 12'h888;
   localparam logic [11:0] C_LIGHT = 12'hFFF;
   localparam logic [11:0] C_DARK  = 12'h444;

   typedef struct {
      logic [10:0] x;
      logic [10:0] y;
      logic [11:0] rgb;
   } pix_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        draw_button;
   logic [10:0] button_xpos;
   logic [10:0] button_ypos;
   logic [6:0]  button_size;
   logic [4:0]  button_num;
   logic        fb_ready;
   logic        fb_we;
   logic [10:0] fb_x;
   logic [10:0] fb_y;
   logic [11:0] fb_rgb;
   logic        done_x;
   logic        done_y;
   logic        busy;

   int   n_cmp = 0;
   int   n_err = 0;
   int   btn_since_reset = 0;
   pix_t got_q[$];

   button_renderer dut (
      .clk(clk), .rst_n(rst_n), .draw_button(draw_button),
      .button_xpos(button_xpos), .button_ypos(button_ypos),
      .button_size(button_size), .button_num(button_num),
      .fb_ready(fb_ready), .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y),
      .fb_rgb(fb_rgb), .done_x(done_x), .done_y(done_y), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] ref_colour(int c, int r, int s);
      if (c < BORDER || r < BORDER) return C_LIGHT;
      if (c >= s - BORDER || r >= s - BORDER) return C_DARK;
      return C_FACE;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      draw_button = 1'b0;
      fb_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      btn_since_reset = 0;
   endtask

   // Issue one request and follow it until busy drops, checking everything.
   task automatic run_button(input logic [10:0] x, input logic [10:0] y,
                             input logic [6:0] s, input bit rnd,
                             output logic dy_seen);
      pix_t exp_q[$];
      pix_t p;
      int   n, cyc, first_we, last_acc, n_dx, dx_cyc, budget, end_cyc;
      bit   stalled;
      logic [10:0] sx, sy;
      logic [11:0] srgb;
      logic exp_dy;
      for (int r = 0; r < int'(s); r++)
         for (int c = 0; c < int'(s); c++) begin
            p.x = 11'((int'(x) + c) % 2048);
            p.y = 11'((int'(y) + r) % 2048);
            p.rgb = ref_colour(c, r, int'(s));
            exp_q.push_back(p);
         end
      exp_dy = (button_num <= 5'd1) ||
               ((btn_since_reset % int'(button_num)) == int'(button_num) - 1);
      got_q.delete();
      dy_seen = 1'b0;
      n = 0; first_we = -1; last_acc = -1; n_dx = 0; dx_cyc = -1; end_cyc = -1;
      stalled = 1'b0; sx = '0; sy = '0; srgb = '0;
      budget = 20 * int'(s) * int'(s) + 50;
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++; $display("FAIL idle_before_req: busy=%b want 0", busy);
      end
      button_xpos = x; button_ypos = y; button_size = s; draw_button = 1'b1;
      fb_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      draw_button = 1'b0;
      button_xpos = 11'($urandom); button_ypos = 11'($urandom);
      button_size = 7'($urandom);
      cyc = 1;
      while (cyc < budget) begin
         if (stalled) begin
            n_cmp++;
            if (fb_we !== 1'b1 || fb_x !== sx || fb_y !== sy || fb_rgb !== srgb) begin
               n_err++;
               $display("FAIL stall_stable: we=%b x=%0d y=%0d rgb=%h want 1 %0d %0d %h",
                        fb_we, fb_x, fb_y, fb_rgb, sx, sy, srgb);
            end
         end
         fb_ready = rnd ? 1'($urandom) : 1'b1;
         if (fb_we === 1'b1 && first_we < 0) first_we = cyc;
         if (fb_we === 1'b1 && fb_ready) begin
            p.x = fb_x; p.y = fb_y; p.rgb = fb_rgb;
            got_q.push_back(p);
            n_cmp++;
            if (n >= exp_q.size()) begin
               n_err++;
               $display("FAIL extra_write: write %0d got %0d,%0d want none", n, fb_x, fb_y);
            end else if (fb_x !== exp_q[n].x || fb_y !== exp_q[n].y || fb_rgb !== exp_q[n].rgb) begin
               n_err++;
               $display("FAIL pixel[%0d]: got %0d,%0d,%h want %0d,%0d,%h", n,
                        fb_x, fb_y, fb_rgb, exp_q[n].x, exp_q[n].y, exp_q[n].rgb);
            end
            n++;
            last_acc = cyc;
         end
         stalled = (fb_we === 1'b1) && !fb_ready;
         sx = fb_x; sy = fb_y; srgb = fb_rgb;
         if (done_x === 1'b1) begin
            n_dx++; dx_cyc = cyc; dy_seen = done_y;
            n_cmp++;
            if (done_y !== exp_dy) begin
               n_err++; $display("FAIL done_y: got %b want %b", done_y, exp_dy);
            end
         end else if (done_y === 1'b1) begin
            n_cmp++; n_err++;
            $display("FAIL done_y_alone: got 1 want 0");
         end
         if (busy === 1'b0) begin
            end_cyc = cyc;
            break;
         end
         @(negedge clk);
         cyc++;
      end
      fb_ready = 1'b1;
      n_cmp++;
      if (end_cyc < 0) begin
         n_err++; $display("FAIL timeout: busy=%b after %0d cycles want 0", busy, budget);
      end
      n_cmp++;
      if (n != exp_q.size()) begin
         n_err++; $display("FAIL write_count: got %0d want %0d", n, exp_q.size());
      end
      n_cmp++;
      if (first_we != 2) begin
         n_err++; $display("FAIL latency: first fb_we at cycle %0d want 2", first_we);
      end
      n_cmp++;
      if (n_dx != 1 || dx_cyc != last_acc + 1) begin
         n_err++; $display("FAIL done_x: got %0d pulses at %0d want 1 at %0d",
                           n_dx, dx_cyc, last_acc + 1);
      end
      n_cmp++;
      if (end_cyc != last_acc + 4) begin
         n_err++; $display("FAIL busy_fall: got cycle %0d want %0d", end_cyc, last_acc + 4);
      end
      btn_since_reset++;
   endtask

   task automatic check_zero_outputs(input string tag);
      n_cmp++;
      if (fb_we !== 1'b0 || fb_x !== 11'd0 || fb_y !== 11'd0 || fb_rgb !== 12'd0 ||
          done_x !== 1'b0 || done_y !== 1'b0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL %s: we=%b x=%0d y=%0d rgb=%h dx=%b dy=%b busy=%b want all 0",
                  tag, fb_we, fb_x, fb_y, fb_rgb, done_x, done_y, busy);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         draw_button = 1'($urandom); fb_ready = 1'($urandom);
         button_xpos = 11'($urandom); button_ypos = 11'($urandom);
         button_size = 7'($urandom_range(1, 127)); button_num = 5'($urandom);
         if (i > 0) check_zero_outputs("reset_hold");
      end
      draw_button = 1'b0;
      button_num = 5'd4;
      rst_n = 1'b1;
      btn_since_reset = 0;
      @(negedge clk);
      check_zero_outputs("after_reset");
   endtask

   task automatic test_basic();
      logic dy;
      run_button(11'd100, 11'd50, 7'd4, 1'b0, dy);
   endtask

   task automatic test_colour();
      logic dy;
      run_button(11'($urandom_range(0, 1500)), 11'($urandom_range(0, 1500)), 7'd8, 1'b0, dy);
      n_cmp++;
      if (got_q.size() != 64) begin
         n_err++; $display("FAIL colour_count: got %0d want 64", got_q.size());
      end else begin
         n_cmp++;
         if (got_q[5*8+0].rgb !== 12'hFFF) begin
            n_err++; $display("FAIL colour_0_5: got %h want fff", got_q[5*8+0].rgb);
         end
         n_cmp++;
         if (got_q[3*8+7].rgb !== 12'h444) begin
            n_err++; $display("FAIL colour_7_3: got %h want 444", got_q[3*8+7].rgb);
         end
         n_cmp++;
         if (got_q[0*8+7].rgb !== 12'hFFF) begin
            n_err++; $display("FAIL colour_7_0: got %h want fff", got_q[0*8+7].rgb);
         end
         n_cmp++;
         if (got_q[3*8+3].rgb !== 12'h888) begin
            n_err++; $display("FAIL colour_3_3: got %h want 888", got_q[3*8+3].rgb);
         end
      end
   endtask

   task automatic test_size_zero();
      @(negedge clk);
      draw_button = 1'b1; button_size = 7'd0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_cmp++;
         if (busy !== 1'b0 || fb_we !== 1'b0) begin
            n_err++; $display("FAIL size_zero: busy=%b we=%b want 0 0", busy, fb_we);
         end
      end
      draw_button = 1'b0;
   endtask

   task automatic test_stall();
      logic dy;
      for (int i = 0; i < 6; i++)
         run_button(11'($urandom), 11'($urandom), 7'($urandom_range(1, 20)), 1'b1, dy);
   endtask

   task automatic test_wrap();
      logic dy;
      int wx[4] = '{2046, 2047, 0, 1};
      run_button(11'd2046, 11'd2045, 7'd4, 1'b1, dy);
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (got_q.size() < 4 || got_q[i].x !== 11'(wx[i])) begin
            n_err++;
            $display("FAIL wrap_x[%0d]: got %0d want %0d", i,
                     (got_q.size() > i) ? got_q[i].x : 11'd0, wx[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic dy;
      do_reset();
      button_num = 5'd3;
      for (int i = 0; i < 6; i++) begin
         run_button(11'($urandom), 11'($urandom), 7'($urandom_range(1, 6)), 1'b1, dy);
         n_cmp++;
         if (dy !== ((i == 2) || (i == 5))) begin
            n_err++; $display("FAIL row_pulse[%0d]: got %b want %b", i, dy, (i == 2) || (i == 5));
         end
      end
      for (int k = 0; k < 4; k++) begin
         button_num = (k < 2) ? 5'd1 : 5'd0;
         run_button(11'($urandom), 11'($urandom), 7'($urandom_range(1, 5)), 1'b0, dy);
         n_cmp++;
         if (dy !== 1'b1) begin
            n_err++; $display("FAIL row_pulse_num%0d: got %b want 1", button_num, dy);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic dy;
      int acc;
      bit seen_dx;
      do_reset();
      button_num = 5'd3;
      run_button(11'd10, 11'd20, 7'd3, 1'b0, dy);
      @(negedge clk);
      button_xpos = 11'd300; button_ypos = 11'd400; button_size = 7'd6;
      draw_button = 1'b1; fb_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      draw_button = 1'b0;
      acc = 0; seen_dx = 1'b0;
      for (int cyc = 0; cyc < 100; cyc++) begin
         if (done_x === 1'b1) seen_dx = 1'b1;
         if (fb_we === 1'b1) acc++;
         if (acc == 5) break;
         @(negedge clk);
      end
      n_cmp++;
      if (acc != 5) begin
         n_err++; $display("FAIL mid_writes: got %0d want 5", acc);
      end
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check_zero_outputs("mid_reset");
      n_cmp++;
      if (seen_dx) begin
         n_err++; $display("FAIL mid_done: got done_x pulse want none");
      end
      rst_n = 1'b1;
      btn_since_reset = 0;
      for (int i = 0; i < 3; i++) begin
         run_button(11'($urandom), 11'($urandom), 7'($urandom_range(1, 7)), 1'b1, dy);
         n_cmp++;
         if (dy !== (i == 2)) begin
            n_err++; $display("FAIL mid_col[%0d]: got %b want %b", i, dy, i == 2);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; draw_button = 1'b0; fb_ready = 1'b1;
      button_xpos = '0; button_ypos = '0; button_size = '0; button_num = 5'd4;
      test_reset();
      test_basic();
      test_colour();
      test_size_zero();
      test_stall();
      test_wrap();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
